// File: rtl/useq_ctrl.sv
// Microprogram sequencer: owns the microaddress register and selects the next
// microaddress from fetch, opcode dispatch, conditional branch and halt/resume.
//
// state  | meaning
// S_RUN  | issuing one microword per clock, stalls on mem_wait
// S_HALT | parked on the halt dispatch entry until resume
module useq_ctrl #(
   parameter int               OPC_W   = 6,
   parameter logic [OPC_W-1:0] HLT_OPC = 6'h3E
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      Micro_ins,
   input  logic [15:0]      Next_addr,
   input  logic [OPC_W-1:0] opcode,
   input  logic             flag_z,
   input  logic             mem_wait,
   input  logic             resume,
   output logic [15:0]      MPC_out,
   output logic             dispatch,
   output logic             halted,
   output logic [15:0]      ucycle_cnt
);

   typedef enum logic {
      S_RUN  = 1'b0,
      S_HALT = 1'b1
   } state_e;

   localparam logic [15:0] FETCH_END = 16'h0001;
   localparam logic [15:0] HALT_ADDR = 16'({6'b000001, HLT_OPC, 4'b0000});

   state_e      state_q;
   logic [15:0] mpc_q, mpc_d;
   logic [15:0] cnt_q, cnt_d;
   logic        dispatch_q;
   logic        halted_q;
   logic [15:0] entry_addr;
   logic        fetch_end;
   logic        halt_hit;

   // The microword itself is decoded downstream; only its successor field matters here.
   logic unused_micro;
   assign unused_micro = ^Micro_ins;

   assign entry_addr = 16'({6'b000001, opcode, 4'b0000});
   assign fetch_end  = (mpc_q == FETCH_END);
   assign halt_hit   = (mpc_q == HALT_ADDR);
   assign cnt_d      = cnt_q + 16'd1;

   always_comb begin
      mpc_d = Next_addr;
      if (fetch_end) begin
         mpc_d = entry_addr;
      end else if (halt_hit) begin
         mpc_d = mpc_q;
      end else if (Next_addr[15]) begin
         mpc_d = flag_z ? {1'b0, Next_addr[14:0]} : mpc_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_RUN;
         mpc_q      <= 16'h0000;
         cnt_q      <= 16'h0000;
         dispatch_q <= 1'b0;
         halted_q   <= 1'b0;
      end else begin
         case (state_q)
            S_RUN: begin
               if (mem_wait) begin
                  dispatch_q <= 1'b0;
               end else begin
                  cnt_q      <= cnt_d;
                  mpc_q      <= mpc_d;
                  dispatch_q <= fetch_end;
                  if (!fetch_end && halt_hit) begin
                     state_q  <= S_HALT;
                     halted_q <= 1'b1;
                  end
               end
            end
            S_HALT: begin
               dispatch_q <= 1'b0;
               if (resume) begin
                  state_q  <= S_RUN;
                  mpc_q    <= 16'h0000;
                  halted_q <= 1'b0;
               end
            end
            default: begin
               state_q    <= S_RUN;
               mpc_q      <= 16'h0000;
               dispatch_q <= 1'b0;
               halted_q   <= 1'b0;
            end
         endcase
      end
   end

   assign MPC_out    = mpc_q;
   assign dispatch   = dispatch_q;
   assign halted     = halted_q;
   assign ucycle_cnt = cnt_q;

endmodule

// File: tb/tb_useq_ctrl.sv
// Directed bench for useq_ctrl: each step drives inputs, queues the expected
// post-edge outputs, then pops and checks them one time unit after the edge.
module tb_useq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] Micro_ins;
   logic [15:0] Next_addr;
   logic [5:0]  opcode;
   logic        flag_z;
   logic        mem_wait;
   logic        resume;
   logic [15:0] MPC_out;
   logic        dispatch;
   logic        halted;
   logic [15:0] ucycle_cnt;

   int errors = 0;
   int checks = 0;
   int step_no = 0;

   typedef struct {
      logic [15:0] mpc;
      logic        disp;
      logic        halt;
      logic [15:0] cnt;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] exp_cnt = 16'h0000;
   logic        tb_halted = 1'b0;

   useq_ctrl #(.OPC_W(6), .HLT_OPC(6'h3E)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .Micro_ins  (Micro_ins),
      .Next_addr  (Next_addr),
      .opcode     (opcode),
      .flag_z     (flag_z),
      .mem_wait   (mem_wait),
      .resume     (resume),
      .MPC_out    (MPC_out),
      .dispatch   (dispatch),
      .halted     (halted),
      .ucycle_cnt (ucycle_cnt)
   );

   always #5 clk = ~clk;

   task automatic step(input logic rst_b, input logic [15:0] na, input logic fz,
                       input logic mw, input logic rs, input logic [15:0] e_mpc,
                       input logic e_disp, input logic e_halt);
      exp_t e;
      exp_t got;
      rst_n     = rst_b;
      Next_addr = na;
      flag_z    = fz;
      mem_wait  = mw;
      resume    = rs;
      Micro_ins = {7'b0, $urandom_range(0, 32'h01FF_FFFF)};
      if (!rst_b)                  exp_cnt = 16'h0000;
      else if (!tb_halted && !mw)  exp_cnt = exp_cnt + 16'd1;
      tb_halted = rst_b ? e_halt : 1'b0;
      e.mpc  = e_mpc;
      e.disp = e_disp;
      e.halt = e_halt;
      e.cnt  = exp_cnt;
      sb.push_back(e);
      @(posedge clk);
      #1;
      step_no++;
      got = sb.pop_front();
      checks++;
      assert (MPC_out === got.mpc) else begin
         errors++;
         $error("FAIL mpc step %0d: got %h want %h", step_no, MPC_out, got.mpc);
      end
      checks++;
      assert (dispatch === got.disp) else begin
         errors++;
         $error("FAIL dispatch step %0d: got %b want %b", step_no, dispatch, got.disp);
      end
      checks++;
      assert (halted === got.halt) else begin
         errors++;
         $error("FAIL halted step %0d: got %b want %b", step_no, halted, got.halt);
      end
      checks++;
      assert (ucycle_cnt === got.cnt) else begin
         errors++;
         $error("FAIL ucycle_cnt step %0d: got %h want %h", step_no, ucycle_cnt, got.cnt);
      end
   endtask

   initial begin
      rst_n = 1'b0; Next_addr = 16'h0; opcode = 6'h02; flag_z = 1'b0;
      mem_wait = 1'b0; resume = 1'b0; Micro_ins = 32'h0;

      // reset, then fetch and dispatch opcode 2
      step(1'b0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0);
      step(1'b1, 16'h0001, 0, 0, 0, 16'h0001, 0, 0);
      step(1'b1, 16'h0055, 0, 0, 0, 16'h0420, 1, 0);
      step(1'b1, 16'h0421, 0, 0, 1, 16'h0421, 0, 0);   // resume ignored in RUN
      step(1'b1, 16'h0000, 0, 0, 0, 16'h0000, 0, 0);

      // conditional branch taken, then not taken
      opcode = 6'h14;
      step(1'b1, 16'h0001, 0, 0, 0, 16'h0001, 0, 0);
      step(1'b1, 16'h0000, 0, 0, 0, 16'h0540, 1, 0);
      step(1'b1, 16'h8570, 1, 0, 0, 16'h0570, 0, 0);
      step(1'b1, 16'h0000, 0, 0, 0, 16'h0000, 0, 0);
      step(1'b1, 16'h0001, 0, 0, 0, 16'h0001, 0, 0);
      step(1'b1, 16'h0000, 0, 0, 0, 16'h0540, 1, 0);
      step(1'b1, 16'h8570, 0, 0, 0, 16'h0541, 0, 0);
      step(1'b1, 16'h0000, 1, 0, 0, 16'h0000, 0, 0);   // flag ignored on plain word

      // opcode 0 entry and return to fetch
      opcode = 6'h00;
      step(1'b1, 16'h0001, 0, 0, 0, 16'h0001, 0, 0);
      step(1'b1, 16'h0000, 0, 0, 0, 16'h0400, 1, 0);
      step(1'b1, 16'h0401, 0, 0, 0, 16'h0401, 0, 0);
      step(1'b1, 16'h0000, 0, 0, 0, 16'h0000, 0, 0);

      // stall at end of fetch defers dispatch; stall on entry drops dispatch
      opcode = 6'h02;
      step(1'b1, 16'h0001, 0, 0, 0, 16'h0001, 0, 0);
      step(1'b1, 16'h0000, 0, 1, 0, 16'h0001, 0, 0);
      step(1'b1, 16'h0000, 0, 1, 0, 16'h0001, 0, 0);
      step(1'b1, 16'h0000, 0, 1, 0, 16'h0001, 0, 0);
      step(1'b1, 16'h0000, 0, 0, 0, 16'h0420, 1, 0);
      step(1'b1, 16'h0421, 0, 1, 0, 16'h0420, 0, 0);
      step(1'b1, 16'h0421, 0, 0, 0, 16'h0421, 0, 0);

      // reset mid-instruction while stalled
      step(1'b0, 16'h0500, 1, 1, 1, 16'h0000, 0, 0);

      // conditional fall-through increments across bit 15
      step(1'b1, 16'h7FFF, 0, 0, 0, 16'h7FFF, 0, 0);
      step(1'b1, 16'h8123, 0, 0, 0, 16'h8000, 0, 0);
      step(1'b1, 16'hFFFF, 1, 0, 0, 16'h7FFF, 0, 0);
      step(1'b1, 16'h0000, 0, 0, 0, 16'h0000, 0, 0);

      // halt, hold for 10 cycles with mem_wait toggling, then resume
      opcode = 6'h3E;
      step(1'b1, 16'h0001, 0, 0, 0, 16'h0001, 0, 0);
      step(1'b1, 16'h0000, 0, 0, 0, 16'h07E0, 1, 0);
      step(1'b1, 16'h1234, 1, 0, 0, 16'h07E0, 0, 1);
      for (int i = 0; i < 10; i++)
         step(1'b1, 16'($urandom), 1'(i), 1'(i % 2), 0, 16'h07E0, 0, 1);
      step(1'b1, 16'h0001, 0, 1, 1, 16'h0000, 0, 0);
      step(1'b1, 16'h0001, 0, 0, 0, 16'h0001, 0, 0);

      // halt again, reset while halted
      step(1'b1, 16'h0000, 0, 0, 0, 16'h07E0, 1, 0);
      step(1'b1, 16'h0000, 0, 0, 0, 16'h07E0, 0, 1);
      step(1'b1, 16'h0000, 0, 0, 0, 16'h07E0, 0, 1);
      step(1'b0, 16'h0000, 0, 0, 1, 16'h0000, 0, 0);
      step(1'b1, 16'h0001, 0, 0, 0, 16'h0001, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish want finish by 100000");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/useq_ctrl.md
# useq_ctrl

Microprogram sequencer that reads the control memory. It owns the microprogram counter (`MPC_out`), presents it to the control store, and consumes the returned `Next_addr`/`Micro_ins` pair. It forms the next microaddress from four sources: fetch, opcode dispatch, conditional branch on the ALU zero flag, and halt/resume. It sits between the instruction register/ALU flags and the combinational control memory, and issues one microinstruction per clock.

## Interface
- `OPC_W`, 6: opcode width taken from the IR.
- `HLT_OPC`, 6'h3E: opcode whose dispatch entry is the halt microword.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `Micro_ins` in 32: current microword from control memory. Bits [31:25] are zero; the block does not decode them.
- `Next_addr` in 16: successor field of the current microword.
- `opcode` in OPC_W: IR opcode; must be stable in the cycle `MPC_out`==16'h0001.
- `flag_z` in 1: ALU zero flag, sampled only on conditional-branch words.
- `mem_wait` in 1: datapath/memory stall request; holds the MPC.
- `resume` in 1: single-cycle pulse that leaves the halt state.
- `MPC_out` out 16: registered microaddress driving control memory.
- `dispatch` out 1: registered; 1 for the cycle after a dispatch load.
- `halted` out 1: registered halt indicator.
- `ucycle_cnt` out 16: count of executed (non-stalled, non-halted) microwords; wraps.

## Operation
- States: RUN and HALT. Reset enters RUN with `MPC_out`=16'h0000.
- In RUN, when not stalled, the next MPC is chosen by this priority:
  1. `MPC_out`==16'h0001 (end of fetch): load {6'b000001, opcode, 4'b0000}. Examples: opcode 0 → 16'h0400; opcode 2 → 16'h0420; HLT_OPC → 16'h07E0. Set `dispatch`.
  2. `MPC_out`=={6'b000001, HLT_OPC, 4'b0000}: hold the MPC and go to HALT.
  3. `Next_addr[15]`==1 (conditional word): if `flag_z`, load {1'b0, `Next_addr[14:0]`}; otherwise load `MPC_out`+1 (16-bit, wraps 16'hFFFF→16'h0000).
  4. Otherwise, load `Next_addr`. The value 16'h0000 returns to fetch.
- `mem_wait`=1 in RUN: the MPC, `ucycle_cnt` and state hold, and `dispatch` goes to 0. Stall has priority over rules 1–4, so dispatch is deferred until the stall releases.
- HALT: `MPC_out` holds the halt address and `halted`=1. `mem_wait` is ignored. `resume`=1 loads 16'h0000, returns to RUN and clears `halted` on the same edge.
- `resume` in RUN is ignored.
- `ucycle_cnt` increments on every RUN edge where `mem_wait`=0, including the edge that enters HALT. It wraps 16'hFFFF→0.
- `Micro_ins` is passed through to the datapath by the top level. This block only observes it.

## Timing
- Reset (`rst_n`=0 at an edge): `MPC_out`=0, `dispatch`=0, `halted`=0, `ucycle_cnt`=0, state RUN. Reset overrides stall, halt and resume, including mid-instruction.
- Control memory is combinational. `Next_addr`/`Micro_ins` are valid in the same cycle as `MPC_out`, and the next MPC loads at the following edge: one microword per cycle, zero-latency lookup.
- Fetch-to-dispatch: MPC 0 → 1 → entry takes 2 cycles with no stall. The first execution microword is at cycle 3 after fetch start.
- `dispatch` is high exactly in the cycle `MPC_out` shows the entry address.
- Halt: `halted` rises at the edge after the MPC reaches the halt entry. Resume takes effect at the edge where `resume` is sampled high.
- A conditional branch uses `flag_z` as sampled at the same edge; there is no flag pipelining.

## Test plan
- Reset and fetch: release `rst_n`, `Next_addr`=16'h0001 at MPC 0, opcode=6'h02 → MPC sequence 0000, 0001, 0420. `dispatch`=1 only at 0420. `ucycle_cnt`=2.
- Return to fetch: at MPC 16'h0401 drive `Next_addr`=16'h0000 → next MPC 0000. No dispatch pulse.
- Conditional branch: at MPC 16'h0540 drive `Next_addr`=16'h8570. With `flag_z`=1 → 0570; rerun with `flag_z`=0 → 0541.
- Stall: assert `mem_wait` for 3 cycles at MPC 0001 → MPC stays 0001 and `ucycle_cnt` holds. After release, dispatch to the opcode entry occurs one cycle later.
- Halt/resume: opcode=6'h3E → MPC reaches 07E0, then `halted`=1 and the MPC holds for 10 cycles despite `mem_wait` toggling. A `resume` pulse → MPC 0000 and `halted`=0.
- Reset mid-operation: assert `rst_n`=0 while in HALT and also while at MPC 0421 with `mem_wait`=1 → in both cases MPC=0, `halted`=0 and `ucycle_cnt`=0 after the edge.
